// File: rtl/entry_park_if.sv
// Bundles the parking-entry request and result signals between upstream control and entry_park.
// No storage of its own; all timing belongs to entry_park (one clock from request to result).
// No backpressure: a request is taken every cycle that entry is high.
interface entry_park_if;
  // Request side: a car-entry request and the current free-space bitmap (bit i = 1 means free).
  logic       entry;
  logic [7:0] parking_capacity;

  // Result side: all registered inside entry_park.
  logic [2:0] park_number;
  logic       park_valid;
  logic       reject;
  logic       full;
  logic [3:0] free_count;

  // Upstream control drives requests and observes results.
  modport master (
    output entry,
    output parking_capacity,
    input  park_number,
    input  park_valid,
    input  reject,
    input  full,
    input  free_count
  );

  // The allocator samples requests and drives results.
  modport slave (
    input  entry,
    input  parking_capacity,
    output park_number,
    output park_valid,
    output reject,
    output full,
    output free_count
  );
endinterface

// File: rtl/entry_park.sv
// Assigns the lowest-index free parking space to each entry request and reports occupancy.
// Latency: exactly one clk from sampled entry/parking_capacity to every output; no comb path.
// No backpressure: every high cycle of entry is an independent request, accepted or rejected.
module entry_park (
  input  logic        clk,
  input  logic        rst_n,
  entry_park_if.slave bus
);

  // Combinational view of the sampled bitmap.
  logic [2:0] cand_idx;   // lowest-index free space
  logic       any_free;   // at least one space free
  logic [3:0] pop_cnt;    // number of free spaces, 0..8
  logic [1:0] pair_sum [4];
  logic [2:0] quad_sum [2];
  logic       accept;
  logic       refuse;

  // Registered outputs and their next-state values.
  logic [2:0] park_number_q, park_number_d;
  logic       park_valid_q,  park_valid_d;
  logic       reject_q,      reject_d;
  logic       full_q,        full_d;
  logic [3:0] free_count_q,  free_count_d;

  // Priority encoder: scan from the top down so the lowest set bit is the last to win.
  always_comb begin
    cand_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (bus.parking_capacity[i]) begin
        cand_idx = 3'(i);
      end
    end
  end

  // Population count of the free-space bitmap as a small adder tree.
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      pair_sum[p] = {1'b0, bus.parking_capacity[2*p]} + {1'b0, bus.parking_capacity[2*p+1]};
    end
    quad_sum[0] = {1'b0, pair_sum[0]} + {1'b0, pair_sum[1]};
    quad_sum[1] = {1'b0, pair_sum[2]} + {1'b0, pair_sum[3]};
    pop_cnt     = {1'b0, quad_sum[0]} + {1'b0, quad_sum[1]};
  end

  // Next-state: a request is granted when any space is free, otherwise refused; the
  // assigned index only moves on a grant, occupancy flags follow the bitmap every cycle.
  always_comb begin
    any_free      = |bus.parking_capacity;
    accept        = bus.entry & any_free;
    refuse        = bus.entry & ~any_free;
    park_number_d = park_number_q;
    if (accept) begin
      park_number_d = cand_idx;
    end
    park_valid_d  = accept;
    reject_d      = refuse;
    full_d        = ~any_free;
    free_count_d  = pop_cnt;
  end

  // Output registers; reset clears everything at once so a request in flight is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      park_number_q <= 3'd0;
      park_valid_q  <= 1'b0;
      reject_q      <= 1'b0;
      full_q        <= 1'b0;
      free_count_q  <= 4'd0;
    end else begin
      park_number_q <= park_number_d;
      park_valid_q  <= park_valid_d;
      reject_q      <= reject_d;
      full_q        <= full_d;
      free_count_q  <= free_count_d;
    end
  end

  assign bus.park_number = park_number_q;
  assign bus.park_valid  = park_valid_q;
  assign bus.reject      = reject_q;
  assign bus.full        = full_q;
  assign bus.free_count  = free_count_q;

endmodule

// File: tb/tb_entry_park.sv
// Bench for entry_park: directed vector table, randomized run against a reference model, reset corners.
// Inputs change on the falling edge; outputs are checked on the next falling edge (one clk later).
// The DUT has no backpressure, so every cycle is one applied vector.
module tb_entry_park;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  entry_park_if bus ();

  entry_park u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       entry;
    logic [7:0] cap;
    logic [2:0] num;
    logic       vld;
    logic       rej;
    logic       full;
    logic [3:0] cnt;
  } vec_t;

  vec_t       tbl [$];
  int         n_vec = 0;
  int         n_bad = 0;
  logic [2:0] model_num;

  task automatic add(input logic e, input logic [7:0] c, input logic [2:0] num,
                     input logic vld, input logic rej, input logic full, input logic [3:0] cnt);
    vec_t v;
    v.entry = e; v.cap = c; v.num = num; v.vld = vld; v.rej = rej; v.full = full; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] num, input logic vld,
                         input logic rej, input logic full, input logic [3:0] cnt);
    chk({tag, ".park_number"}, 8'(bus.park_number), 8'(num));
    chk({tag, ".park_valid"},  8'(bus.park_valid),  8'(vld));
    chk({tag, ".reject"},      8'(bus.reject),      8'(rej));
    chk({tag, ".full"},        8'(bus.full),        8'(full));
    chk({tag, ".free_count"},  8'(bus.free_count),  8'(cnt));
  endtask

  // Reference: first free space counting up from 0.
  function automatic logic [2:0] lowest_free(input logic [7:0] c);
    for (int b = 0; b < 8; b++) begin
      if (c[b]) return 3'(b);
    end
    return 3'd0;
  endfunction

  initial begin
    logic       e;
    logic [7:0] c;

    // Directed table: (entry, capacity) -> expected outputs one clk later.
    for (int i = 0; i < 8; i++) add(1'b0, 8'(1 << i), 3'd0, 1'b0, 1'b0, 1'b0, 4'd1);
    for (int i = 0; i < 8; i++) add(1'b1, 8'(1 << i), 3'(i), 1'b1, 1'b0, 1'b0, 4'd1);
    add(1'b1, 8'h20, 3'd5, 1'b1, 1'b0, 1'b0, 4'd1);
    add(1'b1, 8'h00, 3'd5, 1'b0, 1'b1, 1'b1, 4'd0);
    add(1'b1, 8'hF0, 3'd4, 1'b1, 1'b0, 1'b0, 4'd4);
    add(1'b1, 8'hFF, 3'd0, 1'b1, 1'b0, 1'b0, 4'd8);
    add(1'b1, 8'hA4, 3'd2, 1'b1, 1'b0, 1'b0, 4'd3);
    add(1'b0, 8'h00, 3'd2, 1'b0, 1'b0, 1'b1, 4'd0);
    add(1'b0, 8'hFF, 3'd2, 1'b0, 1'b0, 1'b0, 4'd8);
    add(1'b1, 8'h80, 3'd7, 1'b1, 1'b0, 1'b0, 4'd1);
    add(1'b1, 8'h00, 3'd7, 1'b0, 1'b1, 1'b1, 4'd0);
    add(1'b1, 8'h0C, 3'd2, 1'b1, 1'b0, 1'b0, 4'd2);

    // Reset asserted between edges must clear outputs without a clock.
    rst_n = 1'b1;
    bus.entry = 1'b0;
    bus.parking_capacity = 8'h00;
    #1 rst_n = 1'b0;
    bus.entry = 1'b1;
    bus.parking_capacity = 8'hFF;
    #2 chk_all("reset_async", 3'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    chk_all("reset_held", 3'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    bus.entry = 1'b0;
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      bus.entry = tbl[i].entry;
      bus.parking_capacity = tbl[i].cap;
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), tbl[i].num, tbl[i].vld, tbl[i].rej, tbl[i].full, tbl[i].cnt);
    end

    // Randomized run against the model; empty lots are biased in to exercise reject.
    model_num = 3'd2;
    for (int k = 0; k < 300; k++) begin
      e = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      bus.entry = e;
      bus.parking_capacity = c;
      @(negedge clk);
      if (e && (c != 8'h00)) model_num = lowest_free(c);
      chk_all($sformatf("rnd%0d", k), model_num, e && (c != 8'h00), e && (c == 8'h00),
              c == 8'h00, 4'($countones(c)));
      chk($sformatf("rnd%0d.excl", k), 8'(bus.park_valid & bus.reject), 8'd0);
    end

    // Park in space 6, then pulse reset mid-cycle while the grant is showing.
    bus.entry = 1'b1;
    bus.parking_capacity = 8'h40;
    @(negedge clk);
    chk_all("pre_reset", 3'd6, 1'b1, 1'b0, 1'b0, 4'd1);
    #2 rst_n = 1'b0;
    #1 chk_all("mid_reset", 3'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    bus.entry = 1'b0;
    bus.parking_capacity = 8'h03;
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_all("post_release_idle", 3'd0, 1'b0, 1'b0, 1'b0, 4'd2);

    // Reset with a request pending: the first edge after release evaluates normally.
    bus.entry = 1'b1;
    bus.parking_capacity = 8'h00;
    #2 rst_n = 1'b0;
    bus.parking_capacity = 8'h08;
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk_all("first_edge_after_release", 3'd3, 1'b1, 1'b0, 1'b0, 4'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
